// File: rtl/data_mem_responder.sv
// data_mem_responder
//    Memory-side responder for the GPU's multi-channel data-memory valid/ready
//    interface. Each channel has its own small FSM that accepts a read or a write,
//    waits a programmable number of cycles, then answers with a one-cycle ready
//    pulse. All channels share one backing array, which the host can preload
//    through a direct load port.
//
// Ports
//    clk                rising-edge clock
//    reset              asynchronous, active-high; drops any request in flight
//    mem_read_valid     per-channel read request
//    mem_read_address   per-channel read address, held while valid
//    mem_read_ready     per-channel one-cycle read-response pulse
//    mem_read_data      per-channel read data, holds until the next read response
//    mem_write_valid    per-channel write request
//    mem_write_address  per-channel write address, held while valid
//    mem_write_data     per-channel write data, held while valid
//    mem_write_ready    per-channel one-cycle write-ack pulse
//    load_en            host preload strobe (never produces a ready pulse)
//    load_address       preload address
//    load_data          preload data

module data_mem_responder #(
   parameter int ADDR_BITS    = 8,
   parameter int DATA_BITS    = 8,
   parameter int NUM_CHANNELS = 4,
   parameter int LATENCY      = 2
) (
   input  logic                                   clk,
   input  logic                                   reset,
   input  logic [NUM_CHANNELS-1:0]                mem_read_valid,
   input  logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0] mem_read_address,
   output logic [NUM_CHANNELS-1:0]                mem_read_ready,
   output logic [NUM_CHANNELS-1:0][DATA_BITS-1:0] mem_read_data,
   input  logic [NUM_CHANNELS-1:0]                mem_write_valid,
   input  logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0] mem_write_address,
   input  logic [NUM_CHANNELS-1:0][DATA_BITS-1:0] mem_write_data,
   output logic [NUM_CHANNELS-1:0]                mem_write_ready,
   input  logic                                   load_en,
   input  logic [ADDR_BITS-1:0]                   load_address,
   input  logic [DATA_BITS-1:0]                   load_data
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] WAIT  = 2'd1;
   localparam logic [1:0] RESP  = 2'd2;
   localparam logic [1:0] DRAIN = 2'd3;

   // The counter is loaded with LATENCY-1 at acceptance and the response fires
   // on the edge where WAIT sees zero, so ready rises LATENCY edges after the
   // accepting edge.
   localparam logic [3:0] LAT_LOAD = 4'(LATENCY - 1);

   localparam int DEPTH = 1 << ADDR_BITS;

   logic [DATA_BITS-1:0] mem [0:DEPTH-1];

   logic [NUM_CHANNELS-1:0][1:0]           state;
   logic [NUM_CHANNELS-1:0]                op_write;
   logic [NUM_CHANNELS-1:0][3:0]           count;
   logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0] addr_q;
   logic [NUM_CHANNELS-1:0][DATA_BITS-1:0] wdata_q;

   logic [NUM_CHANNELS-1:0] fire_rd;
   logic [NUM_CHANNELS-1:0] commit_wr;

   // A channel fires on the edge where it sits in WAIT with an expired counter;
   // the operation it latched decides whether that edge reads or writes the array.
   always_comb begin
      fire_rd   = '0;
      commit_wr = '0;
      for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
         if (state[ch] == WAIT && count[ch] == 4'd0) begin
            fire_rd[ch]   = ~op_write[ch];
            commit_wr[ch] = op_write[ch];
         end
      end
   end

   // Per-channel FSMs plus the registered ready pulses and read data. Read has
   // priority in IDLE; DRAIN waits for the initiator to drop the valid that was
   // served so a late registered drop is not mistaken for a new request.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state           <= '0;
         op_write        <= '0;
         count           <= '0;
         addr_q          <= '0;
         wdata_q         <= '0;
         mem_read_ready  <= '0;
         mem_write_ready <= '0;
         mem_read_data   <= '0;
      end else begin
         for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
            case (state[ch])
               IDLE: begin
                  if (mem_read_valid[ch]) begin
                     addr_q[ch]   <= mem_read_address[ch];
                     op_write[ch] <= 1'b0;
                     count[ch]    <= LAT_LOAD;
                     state[ch]    <= WAIT;
                  end else if (mem_write_valid[ch]) begin
                     addr_q[ch]   <= mem_write_address[ch];
                     wdata_q[ch]  <= mem_write_data[ch];
                     op_write[ch] <= 1'b1;
                     count[ch]    <= LAT_LOAD;
                     state[ch]    <= WAIT;
                  end
               end
               WAIT: begin
                  if (count[ch] != 4'd0) begin
                     count[ch] <= count[ch] - 4'd1;
                  end else begin
                     state[ch] <= RESP;
                  end
               end
               RESP: begin
                  state[ch] <= DRAIN;
               end
               default: begin
                  if (op_write[ch] ? !mem_write_valid[ch] : !mem_read_valid[ch]) begin
                     state[ch] <= IDLE;
                  end
               end
            endcase

            mem_read_ready[ch]  <= fire_rd[ch];
            mem_write_ready[ch] <= commit_wr[ch];

            // Non-blocking sampling means a same-edge write is not yet visible,
            // so a colliding read returns the pre-write value.
            if (fire_rd[ch]) begin
               mem_read_data[ch] <= mem[addr_q[ch]];
            end
         end
      end
   end

   // Backing array, deliberately not reset. Channels are applied in ascending
   // order so the highest index wins a same-address collision, and the host
   // load is applied last so it beats every channel write at that edge.
   always_ff @(posedge clk) begin
      for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
         if (commit_wr[ch]) begin
            mem[addr_q[ch]] <= wdata_q[ch];
         end
      end
      if (load_en) begin
         mem[load_address] <= load_data;
      end
   end

endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder
//    Directed bench for data_mem_responder with the default parameters
//    (8-bit address/data, 4 channels, LATENCY = 2). Inputs change 1 ns after
//    each rising edge and outputs are sampled at the same point.

module tb_data_mem_responder;

   localparam int AB = 8;
   localparam int DB = 8;
   localparam int NC = 4;

   logic                   clk;
   logic                   reset;
   logic [NC-1:0]          mem_read_valid;
   logic [NC-1:0][AB-1:0]  mem_read_address;
   logic [NC-1:0]          mem_read_ready;
   logic [NC-1:0][DB-1:0]  mem_read_data;
   logic [NC-1:0]          mem_write_valid;
   logic [NC-1:0][AB-1:0]  mem_write_address;
   logic [NC-1:0][DB-1:0]  mem_write_data;
   logic [NC-1:0]          mem_write_ready;
   logic                   load_en;
   logic [AB-1:0]          load_address;
   logic [DB-1:0]          load_data;

   int nAsserts = 0;
   int nFails   = 0;

   data_mem_responder #(
      .ADDR_BITS(AB), .DATA_BITS(DB), .NUM_CHANNELS(NC), .LATENCY(2)
   ) dut (
      .clk               (clk),
      .reset             (reset),
      .mem_read_valid    (mem_read_valid),
      .mem_read_address  (mem_read_address),
      .mem_read_ready    (mem_read_ready),
      .mem_read_data     (mem_read_data),
      .mem_write_valid   (mem_write_valid),
      .mem_write_address (mem_write_address),
      .mem_write_data    (mem_write_data),
      .mem_write_ready   (mem_write_ready),
      .load_en           (load_en),
      .load_address      (load_address),
      .load_data         (load_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      nAsserts++;
      assert (observed === expected)
      else begin
         nFails++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   task automatic preload(input logic [AB-1:0] a, input logic [DB-1:0] d);
      load_en      = 1'b1;
      load_address = a;
      load_data    = d;
      tick();
      load_en = 1'b0;
   endtask

   // Waits a bounded number of edges for a ready pulse on one channel.
   task automatic waitReady(input int ch, input bit isWrite, output bit found);
      found = 1'b0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (isWrite ? mem_write_ready[ch] : mem_read_ready[ch]) begin
            found = 1'b1;
            break;
         end
      end
   endtask

   task automatic applyStimulusRead(input string tag, input int ch,
                                    input logic [AB-1:0] a, input logic [DB-1:0] expData);
      bit found;
      mem_read_valid[ch]   = 1'b1;
      mem_read_address[ch] = a;
      waitReady(ch, 1'b0, found);
      checkOutput({tag, "_rdy"}, 32'(found), 32'd1);
      checkOutput({tag, "_data"}, 32'(mem_read_data[ch]), 32'(expData));
      mem_read_valid[ch] = 1'b0;
      tick();
      checkOutput({tag, "_width"}, 32'(mem_read_ready[ch]), 32'd0);
      tick();
   endtask

   task automatic applyStimulusWrite(input string tag, input int ch,
                                     input logic [AB-1:0] a, input logic [DB-1:0] d);
      bit found;
      mem_write_valid[ch]   = 1'b1;
      mem_write_address[ch] = a;
      mem_write_data[ch]    = d;
      waitReady(ch, 1'b1, found);
      checkOutput({tag, "_wrdy"}, 32'(found), 32'd1);
      mem_write_valid[ch] = 1'b0;
      tick();
      checkOutput({tag, "_wwidth"}, 32'(mem_write_ready[ch]), 32'd0);
      tick();
   endtask

   initial begin
      bit found;

      reset             = 1'b1;
      mem_read_valid    = '0;
      mem_read_address  = '0;
      mem_write_valid   = '0;
      mem_write_address = '0;
      mem_write_data    = '0;
      load_en           = 1'b0;
      load_address      = '0;
      load_data         = '0;

      // Reset state
      tick();
      tick();
      checkOutput("rst_rd_ready", 32'(mem_read_ready), 32'd0);
      checkOutput("rst_wr_ready", 32'(mem_write_ready), 32'd0);
      checkOutput("rst_rd_data", mem_read_data, 32'd0);
      reset = 1'b0;
      tick();

      // Preloads; the load port must never raise a ready
      preload(8'h10, 8'hAB);
      checkOutput("load_no_ready", 32'({mem_read_ready, mem_write_ready}), 32'd0);
      preload(8'h11, 8'h3D);
      preload(8'h40, 8'h99);
      preload(8'h30, 8'h42);
      preload(8'h50, 8'h12);

      // Exact latency: accept at E, ready visible only after E+2, one cycle wide
      mem_read_valid[0]   = 1'b1;
      mem_read_address[0] = 8'h10;
      tick();
      checkOutput("lat_e0", 32'(mem_read_ready[0]), 32'd0);
      tick();
      checkOutput("lat_e1", 32'(mem_read_ready[0]), 32'd0);
      tick();
      checkOutput("lat_e2", 32'(mem_read_ready[0]), 32'd1);
      checkOutput("lat_data", 32'(mem_read_data[0]), 32'hAB);
      mem_read_valid[0] = 1'b0;
      tick();
      checkOutput("lat_width", 32'(mem_read_ready[0]), 32'd0);
      checkOutput("lat_hold", 32'(mem_read_data[0]), 32'hAB);
      tick();

      // Write then read back from the same and another channel
      applyStimulusWrite("wr1", 1, 8'h20, 8'h5C);
      applyStimulusRead("rd1", 1, 8'h20, 8'h5C);
      applyStimulusRead("rd2", 2, 8'h20, 8'h5C);

      // Drain: valid held after the response must not retrigger
      mem_read_valid[0]   = 1'b1;
      mem_read_address[0] = 8'h10;
      waitReady(0, 1'b0, found);
      checkOutput("drain_rdy", 32'(found), 32'd1);
      for (int i = 0; i < 3; i++) begin
         tick();
         checkOutput("drain_hold", 32'(mem_read_ready[0]), 32'd0);
      end
      mem_read_valid[0] = 1'b0;
      tick();
      tick();
      applyStimulusRead("drain_new", 0, 8'h11, 8'h3D);

      // Same-edge conflict: two writes to 0x40 and a read of 0x40
      mem_write_valid[0]   = 1'b1;
      mem_write_address[0] = 8'h40;
      mem_write_data[0]    = 8'h01;
      mem_write_valid[3]   = 1'b1;
      mem_write_address[3] = 8'h40;
      mem_write_data[3]    = 8'h03;
      mem_read_valid[1]    = 1'b1;
      mem_read_address[1]  = 8'h40;
      waitReady(3, 1'b1, found);
      checkOutput("cf_rdy3", 32'(found), 32'd1);
      checkOutput("cf_rdy0", 32'(mem_write_ready[0]), 32'd1);
      checkOutput("cf_rd_rdy", 32'(mem_read_ready[1]), 32'd1);
      checkOutput("cf_old_val", 32'(mem_read_data[1]), 32'h99);
      mem_write_valid[0] = 1'b0;
      mem_write_valid[3] = 1'b0;
      mem_read_valid[1]  = 1'b0;
      tick();
      tick();
      applyStimulusRead("cf_wins", 2, 8'h40, 8'h03);

      // Priority: read and write raised together on ch2
      mem_read_valid[2]    = 1'b1;
      mem_read_address[2]  = 8'h30;
      mem_write_valid[2]   = 1'b1;
      mem_write_address[2] = 8'h31;
      mem_write_data[2]    = 8'h77;
      waitReady(2, 1'b0, found);
      checkOutput("pri_rd_first", 32'(found), 32'd1);
      checkOutput("pri_no_wack", 32'(mem_write_ready[2]), 32'd0);
      checkOutput("pri_rd_data", 32'(mem_read_data[2]), 32'h42);
      mem_read_valid[2] = 1'b0;
      waitReady(2, 1'b1, found);
      checkOutput("pri_wack", 32'(found), 32'd1);
      mem_write_valid[2] = 1'b0;
      tick();
      tick();
      applyStimulusRead("pri_readback", 0, 8'h31, 8'h77);

      // Reset during WAIT drops the write and clears read data
      mem_write_valid[0]   = 1'b1;
      mem_write_address[0] = 8'h50;
      mem_write_data[0]    = 8'hEE;
      tick();
      reset = 1'b1;
      #1;
      checkOutput("rmid_rd_data", mem_read_data, 32'd0);
      found = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         if (mem_write_ready[0]) found = 1'b1;
      end
      mem_write_valid[0] = 1'b0;
      reset = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         if (mem_write_ready[0]) found = 1'b1;
      end
      checkOutput("rmid_no_wack", 32'(found), 32'd0);
      applyStimulusRead("rmid_unchanged", 0, 8'h50, 8'h12);

      $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
      $finish;
   end

endmodule
